// File: rtl/rle_token_packer.sv
// Run-length token packer.
// Collapses runs of equal samples into {value, count} tokens and buffers them
// in a small first-word-fall-through FIFO behind a valid/ready handshake.
// Samples are never stalled. Tokens that find the FIFO full are dropped and
// recorded in a sticky overflow flag.
//
// state | meaning
// IDLE  | no open run, curVal/cnt not meaningful
// RUN   | curVal/cnt hold the open run, cnt in 1..2^CNT_W-1
module rle_token_packer #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W+CNT_W-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] curVal;
  logic [CNT_W-1:0]  cnt;

  logic              push;
  logic              pop;
  logic              full;
  logic              doWrite;
  logic [TW-1:0]     token;

  logic [TW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wrCnt;
  logic [AW:0]       rdCnt;
  logic              overflowQ;

  // Close the open run on a value change, a saturated count, or a flush.
  always_comb begin
    push  = 1'b0;
    token = {curVal, cnt};
    if (state == RUN) begin
      push = (in_valid && ((in_data != curVal) || (cnt == CNT_MAX))) || flush;
    end
  end

  // Run tracker: open, extend, split or close the current run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      curVal <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            curVal <= in_data;
            cnt    <= CNT_W'(1);
            state  <= RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (push) begin
              curVal <= in_data;
              cnt    <= CNT_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Level is derived from free-running counters so it stays exact across wraps.
  always_comb begin
    fifo_level = wrCnt - rdCnt;
    full       = (fifo_level == LEVEL_FULL);
    out_valid  = (fifo_level != '0);
    pop        = out_valid && out_ready;
    doWrite    = push && (!full || pop);
    out_data   = mem[rdCnt[AW-1:0]];
    overflow   = overflowQ;
  end

  // Token FIFO storage, pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wrCnt     <= '0;
      rdCnt     <= '0;
      overflowQ <= 1'b0;
    end else begin
      if (doWrite) begin
        mem[wrCnt[AW-1:0]] <= token;
        wrCnt              <= wrCnt + (AW+1)'(1);
      end
      if (pop) begin
        rdCnt <= rdCnt + (AW+1)'(1);
      end
      if (push && full && !pop) begin
        overflowQ <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rle_token_packer.md
Name: rle_token_packer

Overview:
- Downstream consumer of the 8-bit per-cycle sample stream produced by the single-state counter stage.
- Run-length encodes consecutive equal samples into {value, count} tokens.
- Buffers tokens in a small FIFO behind a valid/ready output handshake, so a stalling sink does not stall the upstream stage.
- Samples are never backpressured; tokens that cannot be buffered are dropped and flagged.

Parameters:
DATA_W, 8, sample width (matches the upstream 8-bit output).
CNT_W, 4, run-count width; maximum run length is 2^CNT_W-1 (15).
FIFO_DEPTH, 4, token FIFO entries; power of two, at least 2.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous reset, active-low; asserts immediately, releases synchronously to clk.
in_valid  in  1  sample present this cycle.
in_data  in  DATA_W  sample value.
flush  in  1  close the open run at the end of this cycle.
out_valid  out  1  FIFO head token available.
out_ready  in  1  sink accepts the head token.
out_data  out  DATA_W+CNT_W  head token {value[DATA_W+CNT_W-1:CNT_W], count[CNT_W-1:0]}.
fifo_level  out  clog2(FIFO_DEPTH)+1  tokens currently buffered.
overflow  out  1  sticky: a token was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0) puts the block in this state:
  - state=IDLE, cur_val=0, cnt=0.
  - FIFO empty; out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - All outputs are registered, so nothing is combinational from the inputs.
- Reset mid-run discards the open run and all buffered tokens; no partial token is emitted.
- Run-tracker states are IDLE (no open run) and RUN (cur_val/cnt hold the open run).
- IDLE:
  - in_valid=1: cur_val<=in_data, cnt<=1, go to RUN. A flush in the same cycle is ignored.
  - in_valid=0: stay. A flush is a no-op.
- RUN, push condition:
  - A token {cur_val,cnt} is pushed when any of these holds: in_valid=1 and in_data!=cur_val; in_valid=1 and cnt==2^CNT_W-1; flush=1.
- RUN, next state:
  - in_valid=1, in_data==cur_val, cnt<max, flush=0: cnt<=cnt+1, no push.
  - in_valid=1 with a push: the new run starts, cur_val<=in_data, cnt<=1, stay in RUN. With flush=1 the pushed token is the old run and the sample opens a new run.
  - in_valid=0, flush=1: push, go to IDLE, cnt<=0.
  - in_valid=0, flush=0: hold.
- Count arithmetic:
  - cnt never wraps. A run longer than the maximum splits into consecutive tokens with equal value.
  - Example: 17 equal samples give {v,15} then {v,2} (the second after a flush or a value change).
  - A count of 0 is never emitted.
- At most one push per cycle.
- FIFO:
  - First-word-fall-through: out_data/out_valid show the head.
  - Pop occurs when out_valid&out_ready.
  - Push latency is one cycle: a token pushed at edge N is visible at the head after edge N if the FIFO was empty.
  - out_data holds stable while out_valid=1 and out_ready=0.
- FIFO boundary cases:
  - Full with a push and no pop: the token is dropped, fifo_level stays FIFO_DEPTH, and overflow<=1. overflow is sticky until reset.
  - Full with a simultaneous push and pop: both occur, and fifo_level stays FIFO_DEPTH with no overflow.
  - Empty: out_valid=0. out_ready is ignored, with no underflow and no pointer motion.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level=wr_count-rd_count is exact across wraps.
- fifo_level updates by +1, -1 or 0 per cycle, consistent with the push/pop rules.

Test Plan:
- Basic run: reset, out_ready=1, in_valid=1 with samples 5,5,5,9, then flush with in_valid=0 -> tokens {5,3} then {9,1}; out_data=0x53 then 0x91; state returns to IDLE; overflow=0.
- Saturation: 17 consecutive samples of 0xAA, then flush -> tokens {0xAA,15}=0xAAF then {0xAA,2}=0xAA2; no token has count 0.
- Backpressure/overflow: out_ready=0, alternating samples 1,2,1,2,1,2,1 -> 4 tokens buffered (fifo_level=4), the 5th and 6th closed runs are dropped, overflow=1 and stays 1. Then out_ready=1 -> drains {1,1},{2,1},{1,1},{2,1} in order, fifo_level reaches 0, out_valid=0.
- Full with simultaneous push/pop: FIFO full, out_ready=1 in the same cycle a run closes -> fifo_level stays 4, overflow stays 0, and the new token appears last in order.
- Flush corner cases: flush in IDLE -> no token. flush together with in_valid=1 in RUN (run {3,2}, new sample 7) -> token {3,2}, new run starts with cur_val=7 and cnt=1.
- Async reset mid-operation: drive rst=0 between edges with 3 tokens buffered and a run open -> out_valid=0, fifo_level=0, overflow=0 immediately, without waiting for a clock edge. After release, the first sample 4 then flush -> only {4,1} is emitted.
